// File: rtl/rs_param.sv
// Out-of-order reservation station for the integer ALU path: captures dispatched
// ops, snoops the result broadcasts for operand tags, and issues the oldest ready entry.
module rs_param #(
   parameter int DEPTH   = 8,
   parameter int XLEN    = 32,
   parameter int ROB_W   = 4,
   parameter int NUM_CDB = 2,
   parameter int OP_W    = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       rdy,
   input  logic                       flush,
   input  logic                       ins_valid,
   output logic                       ins_ready,
   input  logic [OP_W-1:0]            ins_op,
   input  logic [ROB_W-1:0]           ins_id,
   input  logic                       ins_q1_pend,
   input  logic [ROB_W-1:0]           ins_q1,
   input  logic [XLEN-1:0]            ins_v1,
   input  logic                       ins_q2_pend,
   input  logic [ROB_W-1:0]           ins_q2,
   input  logic [XLEN-1:0]            ins_v2,
   input  logic [NUM_CDB-1:0]         cdb_valid,
   input  logic [NUM_CDB*ROB_W-1:0]   cdb_id,
   input  logic [NUM_CDB*XLEN-1:0]    cdb_val,
   input  logic [ROB_W-1:0]           rob_head,
   output logic                       iss_valid,
   input  logic                       iss_ready,
   output logic [OP_W-1:0]            iss_op,
   output logic [XLEN-1:0]            iss_v1,
   output logic [XLEN-1:0]            iss_v2,
   output logic [ROB_W-1:0]           iss_id,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = IDX_W + 1;

   // Returns {hit, value}; scanning downward lets the lowest matching channel win.
   function automatic logic [XLEN:0] cdb_snoop(
      input logic [ROB_W-1:0]         tag,
      input logic [NUM_CDB-1:0]       vld,
      input logic [NUM_CDB*ROB_W-1:0] ids,
      input logic [NUM_CDB*XLEN-1:0]  vals
   );
      logic [XLEN:0] r;
      r = '0;
      for (int k = NUM_CDB-1; k >= 0; k--)
         if (vld[k] && (ids[k*ROB_W +: ROB_W] == tag))
            r = {1'b1, vals[k*XLEN +: XLEN]};
      return r;
   endfunction

   logic [DEPTH-1:0] busy, pend1, pend2, ready;
   logic [OP_W-1:0]  e_op [DEPTH];
   logic [ROB_W-1:0] e_id [DEPTH];
   logic [ROB_W-1:0] e_q1 [DEPTH];
   logic [ROB_W-1:0] e_q2 [DEPTH];
   logic [XLEN-1:0]  e_v1 [DEPTH];
   logic [XLEN-1:0]  e_v2 [DEPTH];

   logic [XLEN:0]    wk1 [DEPTH];
   logic [XLEN:0]    wk2 [DEPTH];
   logic [XLEN:0]    ins_s1, ins_s2;
   logic [IDX_W-1:0] free_idx, sel_idx;
   logic [ROB_W-1:0] sel_age, age;
   logic             sel_any, iss_open, ins_fire, iss_load;

   assign ins_ready = (count < CNT_W'(DEPTH));
   assign iss_open  = !iss_valid || iss_ready;
   assign ins_fire  = ins_valid && ins_ready && rdy && !flush;
   assign iss_load  = iss_open && sel_any;

   always_comb begin
      ready = busy & ~pend1 & ~pend2;
      free_idx = '0;
      for (int i = DEPTH-1; i >= 0; i--)
         if (!busy[i]) free_idx = IDX_W'(i);
   end

   // Age is distance from the ROB head, modulo the ROB size, so wrap needs no special case.
   always_comb begin
      sel_any = 1'b0;
      sel_idx = '0;
      sel_age = '0;
      age     = '0;
      for (int i = 0; i < DEPTH; i++) begin
         age = e_id[i] - rob_head;
         if (ready[i] && (!sel_any || (age < sel_age))) begin
            sel_any = 1'b1;
            sel_idx = IDX_W'(i);
            sel_age = age;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         wk1[i] = cdb_snoop(e_q1[i], cdb_valid, cdb_id, cdb_val);
         wk2[i] = cdb_snoop(e_q2[i], cdb_valid, cdb_id, cdb_val);
      end
      ins_s1 = cdb_snoop(ins_q1, cdb_valid, cdb_id, cdb_val);
      ins_s2 = cdb_snoop(ins_q2, cdb_valid, cdb_id, cdb_val);
   end

   // Control state and the issue output register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy      <= '0;
         pend1     <= '0;
         pend2     <= '0;
         count     <= '0;
         iss_valid <= 1'b0;
         iss_op    <= '0;
         iss_v1    <= '0;
         iss_v2    <= '0;
         iss_id    <= '0;
      end else if (rdy) begin
         if (flush) begin
            busy      <= '0;
            count     <= '0;
            iss_valid <= 1'b0;
         end else begin
            for (int i = 0; i < DEPTH; i++) begin
               if (busy[i] && pend1[i] && wk1[i][XLEN]) pend1[i] <= 1'b0;
               if (busy[i] && pend2[i] && wk2[i][XLEN]) pend2[i] <= 1'b0;
            end
            if (iss_load) begin
               busy[sel_idx] <= 1'b0;
               iss_valid     <= 1'b1;
               iss_op        <= e_op[sel_idx];
               iss_v1        <= e_v1[sel_idx];
               iss_v2        <= e_v2[sel_idx];
               iss_id        <= e_id[sel_idx];
            end else if (iss_open) begin
               iss_valid <= 1'b0;
            end
            if (ins_fire) begin
               busy[free_idx]  <= 1'b1;
               pend1[free_idx] <= ins_q1_pend && !ins_s1[XLEN];
               pend2[free_idx] <= ins_q2_pend && !ins_s2[XLEN];
            end
            count <= count + CNT_W'(ins_fire) - CNT_W'(iss_load);
         end
      end
   end

   // Entry payload: written on insert, operand values latched on wakeup
   always_ff @(posedge clk) begin
      if (rdy && !flush) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (busy[i] && pend1[i] && wk1[i][XLEN]) e_v1[i] <= wk1[i][XLEN-1:0];
            if (busy[i] && pend2[i] && wk2[i][XLEN]) e_v2[i] <= wk2[i][XLEN-1:0];
         end
         if (ins_fire) begin
            e_op[free_idx] <= ins_op;
            e_id[free_idx] <= ins_id;
            e_q1[free_idx] <= ins_q1;
            e_q2[free_idx] <= ins_q2;
            e_v1[free_idx] <= (ins_q1_pend && ins_s1[XLEN]) ? ins_s1[XLEN-1:0] : ins_v1;
            e_v2[free_idx] <= (ins_q2_pend && ins_s2[XLEN]) ? ins_s2[XLEN-1:0] : ins_v2;
         end
      end
   end

endmodule

// File: tb/tb_rs_param.sv
// Scoreboard bench for rs_param: expected issues are queued as stimulus is driven
// and popped whenever the ALU handshake completes.
module tb_rs_param;
   localparam int DEPTH   = 8;
   localparam int XLEN    = 32;
   localparam int ROB_W   = 4;
   localparam int NUM_CDB = 2;
   localparam int OP_W    = 4;

   logic                     clk, rst, rdy, flush;
   logic                     ins_valid, ins_ready;
   logic [OP_W-1:0]          ins_op;
   logic [ROB_W-1:0]         ins_id, ins_q1, ins_q2;
   logic                     ins_q1_pend, ins_q2_pend;
   logic [XLEN-1:0]          ins_v1, ins_v2;
   logic [NUM_CDB-1:0]       cdb_valid;
   logic [NUM_CDB*ROB_W-1:0] cdb_id;
   logic [NUM_CDB*XLEN-1:0]  cdb_val;
   logic [ROB_W-1:0]         rob_head;
   logic                     iss_valid, iss_ready;
   logic [OP_W-1:0]          iss_op;
   logic [XLEN-1:0]          iss_v1, iss_v2;
   logic [ROB_W-1:0]         iss_id;
   logic [$clog2(DEPTH):0]   count;

   typedef struct packed {
      logic [OP_W-1:0]  op;
      logic [ROB_W-1:0] id;
      logic [XLEN-1:0]  v1;
      logic [XLEN-1:0]  v2;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   rs_param #(.DEPTH(DEPTH), .XLEN(XLEN), .ROB_W(ROB_W), .NUM_CDB(NUM_CDB), .OP_W(OP_W)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
      .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_op(ins_op), .ins_id(ins_id),
      .ins_q1_pend(ins_q1_pend), .ins_q1(ins_q1), .ins_v1(ins_v1),
      .ins_q2_pend(ins_q2_pend), .ins_q2(ins_q2), .ins_v2(ins_v2),
      .cdb_valid(cdb_valid), .cdb_id(cdb_id), .cdb_val(cdb_val), .rob_head(rob_head),
      .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op),
      .iss_v1(iss_v1), .iss_v2(iss_v2), .iss_id(iss_id), .count(count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ins(input logic [ROB_W-1:0] id, input logic p1, input logic [ROB_W-1:0] q1,
                      input logic [XLEN-1:0] v1);
      ins_valid   = 1'b1;
      ins_op      = id;
      ins_id      = id;
      ins_q1_pend = p1;
      ins_q1      = q1;
      ins_v1      = v1;
      ins_q2_pend = 1'b0;
      ins_q2      = '0;
      ins_v2      = 32'h200 + 32'(id);
   endtask

   function automatic exp_t mk(input logic [ROB_W-1:0] id, input logic [XLEN-1:0] v1);
      exp_t e;
      e.op = id;
      e.id = id;
      e.v1 = v1;
      e.v2 = 32'h200 + 32'(id);
      return e;
   endfunction

   task automatic cdb(input logic ch, input logic [ROB_W-1:0] tag, input logic [XLEN-1:0] val);
      if (!ch) begin
         cdb_valid[0]   = 1'b1;
         cdb_id[3:0]    = tag;
         cdb_val[31:0]  = val;
      end else begin
         cdb_valid[1]   = 1'b1;
         cdb_id[7:4]    = tag;
         cdb_val[63:32] = val;
      end
   endtask

   task automatic wait_drain(input int max_cyc);
      for (int i = 0; i < max_cyc && sb.size() != 0; i++) tick();
      chk("drain", 64'(sb.size()), 64'd0);
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst && iss_valid && iss_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_issue", 64'(sb.size()), 64'd1);
         end else begin
            e = sb.pop_front();
            chk("iss_id", 64'(iss_id), 64'(e.id));
            chk("iss_op", 64'(iss_op), 64'(e.op));
            chk("iss_v1", 64'(iss_v1), 64'(e.v1));
            chk("iss_v2", 64'(iss_v2), 64'(e.v2));
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b0; rdy = 1'b1; flush = 1'b0; iss_ready = 1'b1; rob_head = '0;
      ins_valid = 1'b0; ins_op = '0; ins_id = '0; ins_q1_pend = 1'b0; ins_q1 = '0; ins_v1 = '0;
      ins_q2_pend = 1'b0; ins_q2 = '0; ins_v2 = '0;
      cdb_valid = '0; cdb_id = '0; cdb_val = '0;
      tick(); tick();
      chk("rst_iss_valid", 64'(iss_valid), 64'd0);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_ins_ready", 64'(ins_ready), 64'd1);
      chk("rst_iss_id", 64'(iss_id), 64'd0);
      chk("rst_iss_v1", 64'(iss_v1), 64'd0);
      rst = 1'b1;
      tick();

      // global enable low: insert must not take effect
      rdy = 1'b0;
      ins(4'd6, 1'b0, 4'd0, 32'h66);
      tick(); tick();
      chk("rdy0_count", 64'(count), 64'd0);
      chk("rdy0_iss_valid", 64'(iss_valid), 64'd0);
      ins_valid = 1'b0;
      rdy = 1'b1;

      // basic insert and issue one cycle later
      ins(4'd3, 1'b0, 4'd0, 32'd5);
      ins_op = 4'd0;
      ins_v2 = 32'd7;
      sb.push_back('{op: 4'd0, id: 4'd3, v1: 32'd5, v2: 32'd7});
      tick();
      ins_valid = 1'b0;
      chk("t1_count_ins", 64'(count), 64'd1);
      chk("t1_not_yet", 64'(iss_valid), 64'd0);
      tick();
      chk("t1_iss_valid", 64'(iss_valid), 64'd1);
      chk("t1_iss_id", 64'(iss_id), 64'd3);
      chk("t1_count_iss", 64'(count), 64'd0);
      tick();
      chk("t1_drained", 64'(iss_valid), 64'd0);

      // wakeup through channel 1
      ins(4'd4, 1'b1, 4'd2, 32'd0);
      ins_op = 4'd1;
      ins_v2 = 32'd9;
      sb.push_back('{op: 4'd1, id: 4'd4, v1: 32'h55, v2: 32'd9});
      tick();
      ins_valid = 1'b0;
      tick();
      chk("t2_no_early", 64'(iss_valid), 64'd0);
      cdb(1'b1, 4'd2, 32'h55);
      tick();
      cdb_valid = '0;
      chk("t2_wake_not_ready", 64'(iss_valid), 64'd0);
      tick();
      chk("t2_iss_valid", 64'(iss_valid), 64'd1);
      chk("t2_iss_v1", 64'(iss_v1), 64'h55);
      tick();

      // backpressure, entries later drain in age order
      iss_ready = 1'b0;
      ins(4'd5, 1'b0, 4'd0, 32'h105); sb.push_back(mk(4'd5, 32'h105)); tick();
      ins(4'd8, 1'b0, 4'd0, 32'h108); tick();
      ins(4'd6, 1'b0, 4'd0, 32'h106); tick();
      ins(4'd7, 1'b0, 4'd0, 32'h107);
      sb.push_back(mk(4'd6, 32'h106));
      sb.push_back(mk(4'd7, 32'h107));
      sb.push_back(mk(4'd8, 32'h108));
      tick();
      ins_valid = 1'b0;
      tick(); tick();
      chk("t3_hold_valid", 64'(iss_valid), 64'd1);
      chk("t3_hold_id", 64'(iss_id), 64'd5);
      chk("t3_hold_v1", 64'(iss_v1), 64'h105);
      chk("t3_hold_count", 64'(count), 64'd3);
      iss_ready = 1'b1;
      tick(); chk("t3_order0", 64'(iss_id), 64'd6);
      tick(); chk("t3_order1", 64'(iss_id), 64'd7);
      tick(); chk("t3_order2", 64'(iss_id), 64'd8);
      tick(); chk("t3_empty", 64'(iss_valid), 64'd0);
      chk("t3_count", 64'(count), 64'd0);

      // ROB wrap with a broadcast on both channels, channel 0 value wins
      rob_head = 4'd14;
      ins(4'd1, 1'b1, 4'd9, 32'd0);  tick();
      ins(4'd15, 1'b1, 4'd9, 32'd0); tick();
      ins(4'd14, 1'b1, 4'd9, 32'd0); tick();
      ins_valid = 1'b0;
      chk("t4_pending", 64'(iss_valid), 64'd0);
      cdb(1'b0, 4'd9, 32'h1234);
      cdb(1'b1, 4'd9, 32'h9999);
      sb.push_back(mk(4'd14, 32'h1234));
      sb.push_back(mk(4'd15, 32'h1234));
      sb.push_back(mk(4'd1, 32'h1234));
      tick();
      cdb_valid = '0;
      tick(); chk("t4_wrap0", 64'(iss_id), 64'd14);
      tick(); chk("t4_wrap1", 64'(iss_id), 64'd15);
      tick(); chk("t4_wrap2", 64'(iss_id), 64'd1);
      tick(); chk("t4_empty", 64'(iss_valid), 64'd0);

      // fill to capacity; an extra insert is refused
      rob_head = 4'd0;
      for (int i = 0; i < DEPTH; i++) begin
         ins(4'(i), 1'b1, 4'd10, 32'd0);
         tick();
      end
      ins(4'd9, 1'b0, 4'd0, 32'h77);
      chk("t5_full_ready", 64'(ins_ready), 64'd0);
      chk("t5_full_count", 64'(count), 64'd8);
      tick();
      ins_valid = 1'b0;
      chk("t5_refused_count", 64'(count), 64'd8);
      tick();
      chk("t5_none_issued", 64'(iss_valid), 64'd0);
      cdb(1'b1, 4'd10, 32'hBEEF);
      for (int i = 0; i < DEPTH; i++) sb.push_back(mk(4'(i), 32'hBEEF));
      tick();
      cdb_valid = '0;
      wait_drain(20);
      tick();
      chk("t5_count_zero", 64'(count), 64'd0);

      // same-cycle capture of both operands on insert
      ins(4'd12, 1'b1, 4'd11, 32'd0);
      ins_q2_pend = 1'b1;
      ins_q2 = 4'd13;
      cdb(1'b0, 4'd13, 32'h222);
      cdb(1'b1, 4'd11, 32'h111);
      sb.push_back('{op: 4'd12, id: 4'd12, v1: 32'h111, v2: 32'h222});
      tick();
      ins_valid = 1'b0;
      ins_q2_pend = 1'b0;
      cdb_valid = '0;
      chk("t6_count", 64'(count), 64'd1);
      tick();
      chk("t6_capture_valid", 64'(iss_valid), 64'd1);
      chk("t6_capture_v1", 64'(iss_v1), 64'h111);
      chk("t6_capture_v2", 64'(iss_v2), 64'h222);
      tick();

      // flush with busy entries, a held issue and a concurrent insert
      iss_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         ins(4'(i), 1'b0, 4'd0, 32'h300);
         tick();
      end
      ins_valid = 1'b0;
      chk("t7_pre_count", 64'(count), 64'd5);
      chk("t7_pre_valid", 64'(iss_valid), 64'd1);
      flush = 1'b1;
      ins(4'd7, 1'b0, 4'd0, 32'h307);
      tick();
      flush = 1'b0;
      ins_valid = 1'b0;
      chk("t7_flush_count", 64'(count), 64'd0);
      chk("t7_flush_valid", 64'(iss_valid), 64'd0);
      iss_ready = 1'b1;
      tick(); tick();
      chk("t7_no_insert", 64'(iss_valid), 64'd0);
      chk("t7_count_after", 64'(count), 64'd0);

      // asynchronous reset mid-cycle
      iss_ready = 1'b0;
      ins(4'd2, 1'b0, 4'd0, 32'h400); tick();
      ins(4'd3, 1'b1, 4'd5, 32'd0);   tick();
      ins_valid = 1'b0;
      tick();
      chk("t8_pre_valid", 64'(iss_valid), 64'd1);
      chk("t8_pre_count", 64'(count), 64'd1);
      #2;
      rst = 1'b0;
      #1;
      chk("t8_async_count", 64'(count), 64'd0);
      chk("t8_async_valid", 64'(iss_valid), 64'd0);
      chk("t8_async_id", 64'(iss_id), 64'd0);
      chk("t8_async_ready", 64'(ins_ready), 64'd1);
      tick();
      rst = 1'b1;
      iss_ready = 1'b1;
      tick();
      chk("t8_post_count", 64'(count), 64'd0);
      chk("sb_end", 64'(sb.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/rs_param.md
Name: rs_param

Overview:
- Parametrised out-of-order reservation station for the integer ALU path.
- Holds up to DEPTH dispatched ALU/branch instructions and snoops NUM_CDB result-broadcast channels (ALU, load data, future units) to resolve operand tags.
- Issues the oldest ready entry, measured against the ROB head, to the ALU through a valid/ready handshake with backpressure.
- Sits between decoder/dispatch (which has already read the RF and ROB) and the ALU.

Parameters:
- DEPTH, 8, number of entries; a power of two from 2 to 32.
- XLEN, 32, operand and data width.
- ROB_W, 4, ROB id width.
- NUM_CDB, 2, number of broadcast channels.
- OP_W, 4, ALU op-code width; dispatch supplies an already-translated ALU op.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset; state clears while rst=0.
- rdy  in  1  global enable; when 0, all state holds, and outputs hold except on reset.
- flush  in  1  mispredict flush.
- ins_valid  in  1  dispatch request.
- ins_ready  out  1  entry free (count<DEPTH).
- ins_op  in  OP_W  ALU op.
- ins_id  in  ROB_W  ROB id of the instruction.
- ins_q1_pend  in  1  operand 1 is still waiting on a tag.
- ins_q1  in  ROB_W  tag for operand 1.
- ins_v1  in  XLEN  value for operand 1 (when not pending).
- ins_q2_pend, ins_q2, ins_v2  in  1/ROB_W/XLEN  same for operand 2; for immediate forms dispatch sets pend=0 and v2=imm.
- cdb_valid  in  NUM_CDB  per-channel broadcast valid.
- cdb_id  in  NUM_CDB*ROB_W  broadcast tags; channel k occupies bits [k*ROB_W +: ROB_W].
- cdb_val  in  NUM_CDB*XLEN  broadcast values, packed likewise.
- rob_head  in  ROB_W  ROB id of the oldest in-flight instruction.
- iss_valid  out  1  issue request to the ALU.
- iss_ready  in  1  ALU accepts.
- iss_op  out  OP_W  issued ALU op.
- iss_v1, iss_v2  out  XLEN  issued operands.
- iss_id  out  ROB_W  ROB id of the issued instruction.
- count  out  $clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Reset (rst=0, asynchronous):
  - All busy bits, pend bits and count cleared.
  - iss_valid=0; iss_op/iss_v1/iss_v2/iss_id=0.
  - ins_ready=1 after reset.
- Entry state: busy, op, id, pend1/q1/v1, pend2/q2/v2. An entry is ready when busy && !pend1 && !pend2.
- Insert:
  - Fires when ins_valid && ins_ready && rdy && !flush.
  - Writes the lowest-index free entry.
  - ins_ready is computed from registered count only; a same-cycle issue does not free a slot for an insert in that cycle.
- Same-cycle capture on insert:
  - If ins_qX_pend and some cdb_valid[k] has cdb_id[k]==ins_qX, the entry is written with pend=0 and v=cdb_val[k].
  - The lowest k wins if several channels match.
- Wakeup: every busy entry with pendX && cdb_valid[k] && cdb_id[k]==qX clears pendX and latches cdb_val[k] (lowest k wins). Entries woken this cycle become ready only next cycle.
- Issue output register:
  - Loadable when !iss_valid || iss_ready.
  - If loadable and at least one entry is ready at the start of the cycle, select the entry with minimum age = (id - rob_head) mod 2^ROB_W.
  - Load iss_* from that entry, set iss_valid=1, clear its busy bit.
  - If loadable and no entry is ready: iss_valid<=0.
  - If not loadable: all iss_* hold, and no entry is removed.
  - Ids are unique, so the age minimum is unique.
- Latency: an operand-ready entry appears on iss_valid one cycle after insert. A tag that wakes in cycle t issues at t+1, registered at the t+1 edge.
- Count: count' = count + insert - issue_load. Insert and issue in the same cycle leave count unchanged.
- Flush:
  - Synchronous and takes priority over insert, wakeup and issue.
  - Clears all busy bits and count; iss_valid<=0.
  - ins_* in the flush cycle are ignored.
- rdy=0: nothing changes, including in flush or insert cycles.
- ROB wrap: age arithmetic is modulo 2^ROB_W. An entry with id=0 while rob_head=14 (ROB_W=4) has age 2 and is older than id=15 only if 15 is not within [14,0]; the modular age is used, with no special case.

Test Plan:
- Reset then insert op=ADD, id=3, v1=5, v2=7, no pending -> iss_valid=1 on the next edge with iss_v1=5, iss_v2=7, iss_id=3; count returns to 0 after issue.
- Insert id=4 with q1=2 pending; drive cdb_valid[1]=1, cdb_id=2, cdb_val=0x55 two cycles later -> issues one cycle after the broadcast with iss_v1=0x55; no issue before that.
- Backpressure: hold iss_ready=0 with three ready entries -> iss_* stable, count stays 3; release -> the three entries issue on consecutive cycles in age order.
- Age and wrap: rob_head=14, ready ids 1, 15, 14 inserted in that order -> issue order 14, 15, 1.
- Full and simultaneous events: fill DEPTH=8 -> ins_ready=0 and a further ins_valid is ignored. In one cycle apply an insert whose tag matches a same-cycle cdb -> the new entry captures the value (pend=0).
- Flush with 5 busy entries and iss_valid=1, plus an ins_valid in the same cycle -> count=0, iss_valid=0, nothing inserted. Asserting rst=0 mid-operation clears state immediately without a clock edge.
